// File: rtl/sram_march_sequencer.sv
// sram_march_sequencer: March C- self-test controller for one single-port OpenRAM macro.
// Build option MARCH_STOP_ON_FAIL_EN: the first miscompare ends the run like an abort.
module sram_march_sequencer #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1,
   parameter int ERRCNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   addr_first,
   input  logic [ADDR_W-1:0]   addr_last,
   input  logic [DATA_W-1:0]   pattern,
   output logic                sram_csb,
   output logic                sram_web,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_din,
   input  logic [DATA_W-1:0]   sram_dout,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                cfg_err,
   output logic [ERRCNT_W-1:0] err_count,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [DATA_W-1:0]   fail_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   localparam logic [ERRCNT_W-1:0] ERR_ZERO = {ERRCNT_W{1'b0}};
   localparam logic [ERRCNT_W-1:0] ERR_ONE  = {{(ERRCNT_W-1){1'b0}}, 1'b1};
   localparam logic [ERRCNT_W-1:0] ERR_MAX  = {ERRCNT_W{1'b1}};
   localparam logic [ADDR_W-1:0]   ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0]   ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0]   DATA_ZERO = {DATA_W{1'b0}};
   localparam logic [2:0]          DRAIN_LAST = 3'(READ_LAT - 1);

   // Elements 3 and 4 walk the window downwards.
   function automatic logic is_down(input logic [2:0] elem);
      return (elem == 3'd3) || (elem == 3'd4);
   endfunction

   function automatic logic two_ops(input logic [2:0] elem);
      return (elem != 3'd0) && (elem != 3'd5);
   endfunction

   function automatic logic is_write(input logic [2:0] elem, input logic phase);
      return (elem == 3'd0) || (two_ops(elem) && phase);
   endfunction

   // 1 selects the inverted background word for this op.
   function automatic logic data_one(input logic [2:0] elem, input logic phase);
      logic one;
      case (elem)
         3'd1, 3'd3: one = phase;
         3'd2, 3'd4: one = ~phase;
         default:    one = 1'b0;
      endcase
      return one;
   endfunction

   state_t              state_r, state_nx;
   logic [2:0]          elem_r, elem_nx;
   logic                phase_r, phase_nx;
   logic [ADDR_W-1:0]   addr_r, addr_nx;
   logic [2:0]          drain_cnt_r, drain_nx;
   logic [ADDR_W-1:0]   first_r, last_r;
   logic [DATA_W-1:0]   pat_r;
   logic                csb_r, web_r;
   logic [DATA_W-1:0]   din_r;
   logic                op_rd_r;
   logic [DATA_W-1:0]   op_exp_r;
   logic                busy_r, done_r, pass_r, cfg_err_r, aborted_r;
   logic [ERRCNT_W-1:0] err_cnt_r, err_nx;
   logic [ADDR_W-1:0]   fail_addr_r, fail_addr_nx;
   logic [DATA_W-1:0]   fail_data_r, fail_data_nx;
   logic                pass_nx, cfg_err_nx, aborted_nx;

   logic                pipe_vld_r  [READ_LAT];
   logic [ADDR_W-1:0]   pipe_addr_r [READ_LAT];
   logic [DATA_W-1:0]   pipe_exp_r  [READ_LAT];

   logic                issue_s, cfg_bad_s, start_ok_s, mismatch_s, stop_s;
   logic                last_op_s, in_busy_s, wr_nx_s;
   logic [ADDR_W-1:0]   elem_end_s;
   logic [DATA_W-1:0]   pat_sel_s, word_s;

   assign cfg_bad_s  = addr_first > addr_last;
   assign start_ok_s = (state_r == S_IDLE) && start;
   assign in_busy_s  = (state_r == S_RUN) || (state_r == S_DRAIN);
   assign elem_end_s = is_down(elem_r) ? first_r : last_r;
   assign last_op_s  = (elem_r == 3'd5) && (addr_r == last_r);
   assign mismatch_s = pipe_vld_r[READ_LAT-1] && (sram_dout != pipe_exp_r[READ_LAT-1]);
`ifdef MARCH_STOP_ON_FAIL_EN
   assign stop_s     = abort || mismatch_s;
`else
   assign stop_s     = abort;
`endif

   // Next-op sequencing: elem/phase/addr always describe the op currently on the bus.
   always_comb begin
      state_nx = state_r;
      elem_nx  = elem_r;
      phase_nx = phase_r;
      addr_nx  = addr_r;
      drain_nx = drain_cnt_r;
      issue_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start && cfg_bad_s) begin
               state_nx = S_FIN;
            end else if (start) begin
               state_nx = S_RUN;
               elem_nx  = 3'd0;
               phase_nx = 1'b0;
               addr_nx  = addr_first;
               issue_s  = 1'b1;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_RUN: begin
            if (stop_s || last_op_s) begin
               state_nx = S_DRAIN;
               drain_nx = 3'd0;
            end else begin
               issue_s = 1'b1;
               if (two_ops(elem_r) && !phase_r) begin
                  phase_nx = 1'b1;
               end else if (addr_r == elem_end_s) begin
                  // Element ends on address equality, so a window at the top never wraps.
                  elem_nx  = elem_r + 3'd1;
                  phase_nx = 1'b0;
                  addr_nx  = is_down(elem_r + 3'd1) ? last_r : first_r;
               end else begin
                  phase_nx = 1'b0;
                  addr_nx  = is_down(elem_r) ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
               end
            end
         end
         S_DRAIN: begin
            if (drain_cnt_r == DRAIN_LAST) begin
               state_nx = S_FIN;
            end else begin
               drain_nx = drain_cnt_r + 3'd1;
            end
         end
         S_FIN: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Data word of the op about to be issued; the first op uses the live pattern.
   always_comb begin
      wr_nx_s   = is_write(elem_nx, phase_nx);
      pat_sel_s = (state_r == S_IDLE) ? pattern : pat_r;
      word_s    = data_one(elem_nx, phase_nx) ? ~pat_sel_s : pat_sel_s;
   end

   // Result bookkeeping: saturating miscompare count, first-fail capture, pass/abort flags.
   always_comb begin
      err_nx       = err_cnt_r;
      fail_addr_nx = fail_addr_r;
      fail_data_nx = fail_data_r;
      pass_nx      = pass_r;
      cfg_err_nx   = cfg_err_r;
      aborted_nx   = aborted_r;
      if (start_ok_s) begin
         err_nx       = ERR_ZERO;
         fail_addr_nx = ADDR_ZERO;
         fail_data_nx = DATA_ZERO;
         pass_nx      = 1'b0;
         cfg_err_nx   = cfg_bad_s;
         aborted_nx   = 1'b0;
      end else begin
         if (mismatch_s && (err_cnt_r == ERR_ZERO)) begin
            fail_addr_nx = pipe_addr_r[READ_LAT-1];
            fail_data_nx = sram_dout;
         end else begin
            fail_addr_nx = fail_addr_r;
            fail_data_nx = fail_data_r;
         end
         if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
            err_nx = err_cnt_r + ERR_ONE;
         end else begin
            err_nx = err_cnt_r;
         end
         if (abort && in_busy_s) begin
            aborted_nx = 1'b1;
         end else begin
            aborted_nx = aborted_r;
         end
         if ((state_r == S_DRAIN) && (state_nx == S_FIN)) begin
            pass_nx = (err_nx == ERR_ZERO) && !aborted_nx;
         end else begin
            pass_nx = pass_r;
         end
      end
   end

   // Control, bus and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_IDLE;
         elem_r      <= 3'd0;
         phase_r     <= 1'b0;
         addr_r      <= ADDR_ZERO;
         drain_cnt_r <= 3'd0;
         first_r     <= ADDR_ZERO;
         last_r      <= ADDR_ZERO;
         pat_r       <= DATA_ZERO;
         csb_r       <= 1'b1;
         web_r       <= 1'b1;
         din_r       <= DATA_ZERO;
         op_rd_r     <= 1'b0;
         op_exp_r    <= DATA_ZERO;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         cfg_err_r   <= 1'b0;
         aborted_r   <= 1'b0;
         err_cnt_r   <= ERR_ZERO;
         fail_addr_r <= ADDR_ZERO;
         fail_data_r <= DATA_ZERO;
      end else begin
         state_r     <= state_nx;
         elem_r      <= elem_nx;
         phase_r     <= phase_nx;
         addr_r      <= addr_nx;
         drain_cnt_r <= drain_nx;
         if (start_ok_s) begin
            first_r <= addr_first;
            last_r  <= addr_last;
            pat_r   <= pattern;
         end else begin
            first_r <= first_r;
            last_r  <= last_r;
            pat_r   <= pat_r;
         end
         if (issue_s) begin
            csb_r    <= 1'b0;
            web_r    <= ~wr_nx_s;
            din_r    <= wr_nx_s ? word_s : din_r;
            op_rd_r  <= ~wr_nx_s;
            op_exp_r <= word_s;
         end else begin
            csb_r    <= 1'b1;
            web_r    <= 1'b1;
            din_r    <= din_r;
            op_rd_r  <= 1'b0;
            op_exp_r <= op_exp_r;
         end
         busy_r      <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
         done_r      <= (state_nx == S_FIN);
         pass_r      <= pass_nx;
         cfg_err_r   <= cfg_err_nx;
         aborted_r   <= aborted_nx;
         err_cnt_r   <= err_nx;
         fail_addr_r <= fail_addr_nx;
         fail_data_r <= fail_data_nx;
      end
   end

   // Compare pipeline: each read's expectation meets sram_dout READ_LAT cycles later.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < READ_LAT; i++) begin
            pipe_vld_r[i]  <= 1'b0;
            pipe_addr_r[i] <= ADDR_ZERO;
            pipe_exp_r[i]  <= DATA_ZERO;
         end
      end else begin
         pipe_vld_r[0]  <= op_rd_r && !csb_r;
         pipe_addr_r[0] <= addr_r;
         pipe_exp_r[0]  <= op_exp_r;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld_r[i]  <= pipe_vld_r[i-1];
            pipe_addr_r[i] <= pipe_addr_r[i-1];
            pipe_exp_r[i]  <= pipe_exp_r[i-1];
         end
      end
   end

   assign sram_csb  = csb_r;
   assign sram_web  = web_r;
   assign sram_addr = addr_r;
   assign sram_din  = din_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign cfg_err   = cfg_err_r;
   assign err_count = err_cnt_r;
   assign fail_addr = fail_addr_r;
   assign fail_data = fail_data_r;

endmodule
